hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline-control counterpart to the forwarding logic in the RV32I 5-stage core.
- Forwarding resolves RAW hazards by supplying in-flight data; this block handles the cases where data cannot be supplied:
  - load-use hazards, by inserting a bubble;
  - data-memory wait states, by freezing the whole pipeline;
  - taken branches/jumps, by squashing fetched instructions for one or more cycles.
- It drives the pipeline-register write enables, flushes and bubbles, and keeps stall/flush performance counters plus a sticky memory-timeout flag.

Parameters:
- ADDRESS_PORT_WIDTH, 5, register-index width (shared package constant).
- REDIRECT_CYCLES, 1, cycles IF_ID_Flush stays asserted after a taken branch (minimum 1).
- MEM_TIMEOUT, 255, maximum consecutive data-memory wait cycles before mem_timeout is set.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_RS1, ID_RS2  in  ADDRESS_PORT_WIDTH  source indices of the instruction in ID.
- ID_UsesRS1, ID_UsesRS2  in  1  the ID instruction actually reads rs1/rs2.
- ID_EX_RD  in  ADDRESS_PORT_WIDTH  destination of the instruction in EX.
- ID_EX_MemRead  in  1  the EX instruction is a load.
- BranchTaken_EX  in  1  taken branch/jump resolved in EX.
- DMem_Req  in  1  the MEM stage is issuing a data-memory access.
- DMem_Ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  clear IF/ID to NOP.
- ID_EX_Bubble  out  1  load ID/EX with NOP (control zeroed).
- ID_EX_Flush  out  1  clear ID/EX (branch squash).
- EX_MEM_Hold  out  1  hold EX/MEM and ID/EX contents.
- MEM_WB_Bubble  out  1  load MEM/WB with NOP (RegWrite=0).
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_WIDTH  count of cycles with PC_Write=0.
- flush_events  out  CNT_WIDTH  count of taken-branch redirects accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM returns to S_RUN; counters, the wait counter and mem_timeout clear to 0.
  - Outputs while in reset: PC_Write=1, IF_ID_Write=1, all flush/bubble/hold outputs 0.
- Reset mid-operation:
  - Abandons any MEM_WAIT or REDIRECT immediately.
  - No pending squash survives reset.
- Hazard conditions (combinational):
  - memwait = DMem_Req & ~DMem_Ready.
  - loaduse = ID_EX_MemRead & (ID_EX_RD!=0) & ((ID_UsesRS1 & ID_EX_RD==ID_RS1) | (ID_UsesRS2 & ID_EX_RD==ID_RS2)).
- FSM states: S_RUN, S_MEM_WAIT, S_REDIRECT. All outputs are Mealy on the current state and inputs.
- Priority, applied each cycle from highest to lowest:
  - 1) memwait:
    - PC_Write=0, IF_ID_Write=0, EX_MEM_Hold=1, MEM_WB_Bubble=1; no flush or bubble.
    - Next state is S_MEM_WAIT.
    - BranchTaken_EX is ignored. EX is frozen, so the branch is re-presented after the wait.
  - 2) BranchTaken_EX:
    - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 (redirect), IF_ID_Write=1.
    - flush_events increments.
    - If REDIRECT_CYCLES>1, go to S_REDIRECT with redirect count = REDIRECT_CYCLES-1.
    - loaduse in the same cycle is overridden, because the ID instruction is squashed.
  - 3) loaduse:
    - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
    - Exactly one bubble per load-use pair. The next cycle the load is in MEM and forwarding covers it.
  - 4) Otherwise: all enables 1, all other outputs 0.
- S_MEM_WAIT:
  - Wait counter increments each cycle memwait holds.
  - On DMem_Ready: return to S_RUN, clear the wait counter, resume normal priority in the same cycle.
  - If the wait counter reaches MEM_TIMEOUT, set mem_timeout (sticky until reset). The stall continues.
- S_REDIRECT:
  - IF_ID_Flush=1 and the redirect count decrements each cycle; return to S_RUN when it reaches 0.
  - A new BranchTaken_EX here reloads the count and increments flush_events.
  - memwait in this state freezes the redirect count and PC_Write=0.
- Counters:
  - stall_cycles increments on every cycle with PC_Write=0.
  - Both counters wrap modulo 2^CNT_WIDTH.
  - Both counters update on the same edge that the counted condition is sampled.
- x0 is never a hazard source (the ID_EX_RD!=0 check).

Decomposition:
- RISCV_PKG gains the hazard_state_t enum (S_RUN, S_MEM_WAIT, S_REDIRECT) and the default constants for MEM_TIMEOUT and REDIRECT_CYCLES. ADDRESS_PORT_WIDTH is reused from the package.
- One natural sub-module, perf_counter: an enable-driven wrapping CNT_WIDTH counter with async active-low reset, instantiated twice.

Test Plan:
- Load-use: lw x5 in EX (ID_EX_MemRead=1, ID_EX_RD=5); ID add reads rs1=5 -> exactly 1 cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles=1.
- x0 and unused-source guards:
  - ID_EX_RD=0 with matching RS1=0 -> no stall.
  - ID_UsesRS2=0 with ID_RS2=5 -> no stall.
- Memory wait:
  - DMem_Req=1, DMem_Ready=0 for 3 cycles, then 1 -> EX_MEM_Hold and MEM_WB_Bubble high for exactly 3 cycles, PC_Write low for 3; stall_cycles=3.
  - A branch asserted during the wait is squashed only after Ready.
- Redirect with REDIRECT_CYCLES=3: BranchTaken_EX pulse -> IF_ID_Flush high for 3 cycles, ID_EX_Flush for 1; flush_events=1.
- Simultaneous events:
  - Branch with loaduse in the same cycle -> no bubble, flush asserted.
  - memwait with branch in the same cycle -> hold only, no flush that cycle.
- Timeout and reset: MEM_TIMEOUT=4, hold Ready=0 for 6 cycles -> mem_timeout set at the 4th wait cycle and stays set; asserting rst_n=0 mid-wait clears mem_timeout and the counters immediately, with PC_Write=1.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control definitions: register-index width, hazard FSM states,
// default stall/redirect constants and the load-use detection rule.
package hazard_stall_unit_pkg;

    localparam int ADDRESS_PORT_WIDTH      = 5;
    localparam int DEFAULT_MEM_TIMEOUT     = 255;
    localparam int DEFAULT_REDIRECT_CYCLES = 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_REDIRECT
    } hazard_state_t;

    // x0 is hard-wired to zero, so a load targeting it can never cause a RAW stall.
    function automatic logic isLoadUse(
        input logic                          memRead,
        input logic [ADDRESS_PORT_WIDTH-1:0] rd,
        input logic [ADDRESS_PORT_WIDTH-1:0] rs1,
        input logic [ADDRESS_PORT_WIDTH-1:0] rs2,
        input logic                          usesRs1,
        input logic                          usesRs2
    );
        return memRead && (rd != '0) &&
               ((usesRs1 && (rd == rs1)) || (usesRs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_perf_counter.sv
// Enable-driven wrapping event counter used for the pipeline performance counters.
module perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, data-memory freezes and
// branch squashes, with stall/flush performance counters and a sticky timeout flag.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REDIRECT_CYCLES = DEFAULT_REDIRECT_CYCLES,
    parameter int MEM_TIMEOUT     = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDRESS_PORT_WIDTH-1:0] ID_RS1,
    input  logic [ADDRESS_PORT_WIDTH-1:0] ID_RS2,
    input  logic                          ID_UsesRS1,
    input  logic                          ID_UsesRS2,
    input  logic [ADDRESS_PORT_WIDTH-1:0] ID_EX_RD,
    input  logic                          ID_EX_MemRead,
    input  logic                          BranchTaken_EX,
    input  logic                          DMem_Req,
    input  logic                          DMem_Ready,
    output logic                          PC_Write,
    output logic                          IF_ID_Write,
    output logic                          IF_ID_Flush,
    output logic                          ID_EX_Bubble,
    output logic                          ID_EX_Flush,
    output logic                          EX_MEM_Hold,
    output logic                          MEM_WB_Bubble,
    output logic                          mem_timeout,
    output logic [CNT_WIDTH-1:0]          stall_cycles,
    output logic [CNT_WIDTH-1:0]          flush_events
);

    localparam int RC_W   = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [RC_W-1:0]   REDIRECT_RELOAD = RC_W'(REDIRECT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX        = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST       = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     state, stateNext;
    logic [RC_W-1:0]   redirectCnt, redirectCntNext;
    logic [WAIT_W-1:0] waitCnt;
    logic              memWait, loadUse, branchAccept;

    assign memWait      = DMem_Req & ~DMem_Ready;
    assign loadUse      = isLoadUse(ID_EX_MemRead, ID_EX_RD, ID_RS1, ID_RS2, ID_UsesRS1, ID_UsesRS2);
    assign branchAccept = BranchTaken_EX & ~memWait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RUN;
            redirectCnt <= '0;
        end else begin
            state       <= stateNext;
            redirectCnt <= redirectCntNext;
        end
    end

    always_comb begin
        stateNext       = state;
        redirectCntNext = redirectCnt;
        unique case (state)
            S_REDIRECT: begin
                // A memory freeze holds the squash window where it is.
                if (memWait) begin
                    stateNext = S_REDIRECT;
                end else if (BranchTaken_EX) begin
                    redirectCntNext = REDIRECT_RELOAD;
                end else if (redirectCnt == RC_W'(1)) begin
                    stateNext       = S_RUN;
                    redirectCntNext = '0;
                end else begin
                    redirectCntNext = redirectCnt - RC_W'(1);
                end
            end
            default: begin
                if (memWait) begin
                    stateNext = S_MEM_WAIT;
                end else if (BranchTaken_EX && (REDIRECT_CYCLES > 1)) begin
                    stateNext       = S_REDIRECT;
                    redirectCntNext = REDIRECT_RELOAD;
                end else begin
                    stateNext = S_RUN;
                end
            end
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch can be inferred.
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Hold   = 1'b0;
        MEM_WB_Bubble = 1'b0;
        if (rst_n) begin
            if (memWait) begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                EX_MEM_Hold   = 1'b1;
                MEM_WB_Bubble = 1'b1;
            end else if (BranchTaken_EX) begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end else if (state == S_REDIRECT) begin
                IF_ID_Flush = 1'b1;
            end else if (loadUse) begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end
        end
    end

    // Wait counter saturates at MEM_TIMEOUT so a stuck memory cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else if (memWait) begin
            if (waitCnt != WAIT_MAX) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end
            if (waitCnt >= WAIT_LAST) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            waitCnt <= '0;
        end
    end

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) stallCounter (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (~PC_Write),
        .count  (stall_cycles)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) flushCounter (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (branchAccept),
        .count  (flush_events)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a cycle-level reference model checked on
// every falling edge, plus hand-computed expectations at key points.
module tb_hazard_stall_unit;

    localparam int REDIRECT_CYCLES = 3;
    localparam int MEM_TIMEOUT     = 4;
    localparam int CNT_WIDTH       = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ID_RS1, ID_RS2, ID_EX_RD;
    logic        ID_UsesRS1, ID_UsesRS2, ID_EX_MemRead;
    logic        BranchTaken_EX, DMem_Req, DMem_Ready;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Flush;
    logic        EX_MEM_Hold, MEM_WB_Bubble, mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles, flush_events;

    int vectors = 0;
    int miscompares = 0;

    hazard_stall_unit #(
        .REDIRECT_CYCLES (REDIRECT_CYCLES),
        .MEM_TIMEOUT     (MEM_TIMEOUT),
        .CNT_WIDTH       (CNT_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_RS1         (ID_RS1),
        .ID_RS2         (ID_RS2),
        .ID_UsesRS1     (ID_UsesRS1),
        .ID_UsesRS2     (ID_UsesRS2),
        .ID_EX_RD       (ID_EX_RD),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .BranchTaken_EX (BranchTaken_EX),
        .DMem_Req       (DMem_Req),
        .DMem_Ready     (DMem_Ready),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .ID_EX_Flush    (ID_EX_Flush),
        .EX_MEM_Hold    (EX_MEM_Hold),
        .MEM_WB_Bubble  (MEM_WB_Bubble),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: remaining squash cycles, consecutive wait cycles, sticky flag, event totals.
    int          squashLeft = 0;
    int          waitRun    = 0;
    bit          timeoutSeen = 1'b0;
    int unsigned stallTotal = 0;
    int unsigned flushTotal = 0;

    always @(negedge clk) begin
        bit mw, lu, br;
        bit ePc, eIfW, eIfF, eBub, eExF, eHold, eWb;
        ePc = 1; eIfW = 1; eIfF = 0; eBub = 0; eExF = 0; eHold = 0; eWb = 0;
        if (!rst_n) begin
            squashLeft = 0; waitRun = 0; timeoutSeen = 0; stallTotal = 0; flushTotal = 0;
        end else begin
            mw = DMem_Req && !DMem_Ready;
            br = BranchTaken_EX;
            lu = ID_EX_MemRead && (ID_EX_RD != 0) &&
                 ((ID_UsesRS1 && ID_EX_RD == ID_RS1) || (ID_UsesRS2 && ID_EX_RD == ID_RS2));
            if (mw) begin
                ePc = 0; eIfW = 0; eHold = 1; eWb = 1;
            end else if (br) begin
                eIfF = 1; eExF = 1;
            end else if (squashLeft > 0) begin
                eIfF = 1;
            end else if (lu) begin
                ePc = 0; eIfW = 0; eBub = 1;
            end
        end
        check("PC_Write", 32'(PC_Write), 32'(ePc));
        check("IF_ID_Write", 32'(IF_ID_Write), 32'(eIfW));
        check("IF_ID_Flush", 32'(IF_ID_Flush), 32'(eIfF));
        check("ID_EX_Bubble", 32'(ID_EX_Bubble), 32'(eBub));
        check("ID_EX_Flush", 32'(ID_EX_Flush), 32'(eExF));
        check("EX_MEM_Hold", 32'(EX_MEM_Hold), 32'(eHold));
        check("MEM_WB_Bubble", 32'(MEM_WB_Bubble), 32'(eWb));
        check("mem_timeout", 32'(mem_timeout), 32'(timeoutSeen));
        check("stall_cycles", stall_cycles, stallTotal);
        check("flush_events", flush_events, flushTotal);
        if (rst_n) begin
            if (!ePc) stallTotal++;
            if (!mw && br) begin
                flushTotal++;
                squashLeft = REDIRECT_CYCLES - 1;
            end else if (!mw && squashLeft > 0) begin
                squashLeft--;
            end
            if (mw) begin
                waitRun++;
                if (waitRun >= MEM_TIMEOUT) timeoutSeen = 1;
            end else begin
                waitRun = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_RS1 = 0; ID_RS2 = 0; ID_UsesRS1 = 0; ID_UsesRS2 = 0;
        ID_EX_RD = 0; ID_EX_MemRead = 0; BranchTaken_EX = 0;
        DMem_Req = 0; DMem_Ready = 0;
    endtask

    initial begin
        int ifFlushCnt, exFlushCnt;
        idle();
        rst_n = 1'b0;
        // Reset must override a pending memory wait on the outputs.
        DMem_Req = 1; DMem_Ready = 0;
        #2;
        check("reset_pc_write", 32'(PC_Write), 32'd1);
        check("reset_hold", 32'(EX_MEM_Hold), 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        tick(); tick();
        idle();
        rst_n = 1'b1;
        tick();

        // Load-use: lw x5 in EX, add reads x5 in ID.
        ID_EX_MemRead = 1; ID_EX_RD = 5; ID_RS1 = 5; ID_UsesRS1 = 1;
        #1;
        check("loaduse_pc_write", 32'(PC_Write), 32'd0);
        check("loaduse_bubble", 32'(ID_EX_Bubble), 32'd1);
        tick();
        idle();
        #1;
        check("loaduse_one_bubble", 32'(ID_EX_Bubble), 32'd0);
        check("loaduse_stall_count", stall_cycles, 32'd1);
        tick();

        // x0 destination never stalls.
        ID_EX_MemRead = 1; ID_EX_RD = 0; ID_RS1 = 0; ID_UsesRS1 = 1;
        #1;
        check("x0_no_stall", 32'(PC_Write), 32'd1);
        tick();
        // Unused rs2 never stalls; used rs2 does.
        idle();
        ID_EX_MemRead = 1; ID_EX_RD = 5; ID_RS2 = 5; ID_UsesRS2 = 0;
        #1;
        check("rs2_unused_no_stall", 32'(ID_EX_Bubble), 32'd0);
        tick();
        ID_UsesRS2 = 1;
        tick();
        idle();
        #1;
        check("rs2_stall_count", stall_cycles, 32'd2);

        // Three-cycle memory wait.
        DMem_Req = 1; DMem_Ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("memwait_hold", 32'(EX_MEM_Hold), 32'd1);
            tick();
        end
        DMem_Ready = 1;
        #1;
        check("memwait_release_hold", 32'(EX_MEM_Hold), 32'd0);
        check("memwait_release_pc", 32'(PC_Write), 32'd1);
        tick();
        idle();
        #1;
        check("memwait_stall_count", stall_cycles, 32'd5);
        check("memwait_no_timeout", 32'(mem_timeout), 32'd0);

        // Branch presented during a wait: hold only, squash after Ready.
        DMem_Req = 1; DMem_Ready = 0; BranchTaken_EX = 1;
        #1;
        check("branch_in_wait_no_flush", 32'(IF_ID_Flush), 32'd0);
        tick();
        DMem_Ready = 1;
        #1;
        check("branch_after_wait_flush", 32'(ID_EX_Flush), 32'd1);
        tick();
        idle();
        tick(); tick(); tick();
        check("branch_after_wait_events", flush_events, 32'd1);

        // Isolated redirect pulse.
        BranchTaken_EX = 1;
        ifFlushCnt = 0; exFlushCnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            ifFlushCnt += int'(IF_ID_Flush);
            exFlushCnt += int'(ID_EX_Flush);
            tick();
            BranchTaken_EX = 0;
        end
        check("redirect_if_flush_cycles", 32'(ifFlushCnt), 32'd3);
        check("redirect_ex_flush_cycles", 32'(exFlushCnt), 32'd1);

        // Branch and load-use together: the squash wins.
        BranchTaken_EX = 1; ID_EX_MemRead = 1; ID_EX_RD = 7; ID_RS1 = 7; ID_UsesRS1 = 1;
        #1;
        check("branch_loaduse_no_bubble", 32'(ID_EX_Bubble), 32'd0);
        check("branch_loaduse_flush", 32'(ID_EX_Flush), 32'd1);
        tick();
        idle();
        tick(); tick(); tick();
        check("branch_loaduse_events", flush_events, 32'd3);

        // Second branch inside the squash window reloads it.
        BranchTaken_EX = 1;
        tick(); tick();
        BranchTaken_EX = 0;
        repeat (4) tick();

        // Memory wait inside the squash window freezes it.
        BranchTaken_EX = 1;
        tick();
        BranchTaken_EX = 0; DMem_Req = 1; DMem_Ready = 0;
        tick(); tick();
        idle();
        repeat (3) tick();

        // Timeout after four consecutive wait cycles, then sticky.
        DMem_Req = 1; DMem_Ready = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 3) check("timeout_not_yet", 32'(mem_timeout), 32'd0);
            if (i == 4) check("timeout_set", 32'(mem_timeout), 32'd1);
        end
        DMem_Ready = 1;
        tick();
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        DMem_Ready = 0;
        tick(); tick();

        // Asynchronous reset mid-wait.
        rst_n = 1'b0;
        #1;
        check("midreset_timeout", 32'(mem_timeout), 32'd0);
        check("midreset_stalls", stall_cycles, 32'd0);
        check("midreset_flushes", flush_events, 32'd0);
        check("midreset_pc_write", 32'(PC_Write), 32'd1);
        tick();
        idle();
        rst_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
